// File: rtl/pontuacao_scan_if.sv
// pontuacao_scan_if: controller/memory bus of the fleet scoring scanner.
// slave = scanner side, master = controller plus fleet memories.
interface pontuacao_scan_if #(
  parameter int N_PLAYERS = 2,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int SCORE_W   = 6
);
  logic                          start;
  logic                          mode;
  logic [N_PLAYERS*DATA_W-1:0]   memoria;
  logic [ADDR_W-1:0]             addr;
  logic                          busy;
  logic                          done;
  logic                          scores_valid;
  logic [N_PLAYERS*SCORE_W-1:0]  scores;
  logic [N_PLAYERS-1:0]          all_sunk;

  modport master (
    output start, mode, memoria,
    input  addr, busy, done, scores_valid, scores, all_sunk
  );

  modport slave (
    input  start, mode, memoria,
    output addr, busy, done, scores_valid, scores, all_sunk
  );
endinterface

// File: rtl/pontuacao_scan.sv
// pontuacao_scan: walks all fleet entries through a shared address and
// accumulates a saturating weighted score and an all-sunk flag per player.
module pontuacao_scan #(
  parameter int N_PLAYERS = 2,
  parameter int NUM_SHIPS = 11,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int ALIVE_MSB = 42,
  parameter int ALIVE_LSB = 3,
  parameter int READ_LAT  = 1,
  parameter int SCORE_W   = 6,
  parameter logic [4*NUM_SHIPS-1:0] WEIGHTS = 44'h54332211111
) (
  input logic clk,
  input logic rst_n,
  pontuacao_scan_if.slave bus
);

  localparam int AW = (SCORE_W + 1 >= 5) ? SCORE_W + 1 : 5;
  localparam int FW = ALIVE_MSB - ALIVE_LSB + 1;
  localparam logic [AW-1:0] SMAX = AW'((2 ** SCORE_W) - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SHIPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t st, nx;

  logic [ADDR_W-1:0]            addr_q;
  logic [ADDR_W-1:0]            widx;
  logic                         mode_q;
  logic [N_PLAYERS*SCORE_W-1:0] acc_q;
  logic [N_PLAYERS*SCORE_W-1:0] acc_d;
  logic [N_PLAYERS*SCORE_W-1:0] scores_q;
  logic [N_PLAYERS-1:0]         all_q;
  logic [N_PLAYERS-1:0]         all_d;
  logic [N_PLAYERS-1:0]         sunk_q;
  logic                         sv_q;
  logic                         go;
  logic                         scan_v;
  logic                         acc_en;
  logic                         last_addr;
  logic                         last_acc;
  logic [3:0]                   wgt;

  assign go        = (st == IDLE) && bus.start;
  assign scan_v    = (st == SCAN);
  assign last_addr = (addr_q == LAST);
  assign last_acc  = acc_en && (widx == LAST);

  // Address-valid delayed by the memory latency marks accumulation edges.
  generate
    if (READ_LAT == 0) begin : g_lat0
      assign acc_en = scan_v;
    end else begin : g_latn
      logic [READ_LAT-1:0] vsh;
      always_ff @(posedge clk) begin
        if (!rst_n || go) vsh <= '0;
        else              vsh <= READ_LAT'({vsh, scan_v});
      end
      assign acc_en = vsh[READ_LAT-1];
    end
  endgenerate

  always_comb begin
    wgt = '0;
    for (int i = 0; i < NUM_SHIPS; i++)
      if (widx == ADDR_W'(i)) wgt = WEIGHTS[4*i +: 4];
  end

  generate
    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pl
      logic [FW-1:0] alive;
      logic          sunk;
      logic [AW-1:0] inc;
      logic [AW-1:0] sum;

      assign alive = bus.memoria[p*DATA_W+ALIVE_LSB +: FW];
      assign sunk  = ~|alive;

      always_comb begin
        inc = '0;
        if (mode_q) inc = sunk ? '0 : AW'(1);
        else        inc = sunk ? AW'(wgt) : '0;
        sum = AW'(acc_q[p*SCORE_W +: SCORE_W]) + inc;
        acc_d[p*SCORE_W +: SCORE_W] =
          (sum > SMAX) ? SMAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
        all_d[p] = all_q[p] & sunk;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      IDLE:  if (bus.start) nx = SCAN;
      SCAN:  if (last_addr) nx = last_acc ? DONE : DRAIN;
      DRAIN: if (last_acc) nx = DONE;
      DONE:  nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      widx     <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      all_q    <= '0;
      scores_q <= '0;
      sunk_q   <= '0;
      sv_q     <= 1'b0;
    end else begin
      if (scan_v && !last_addr) addr_q <= addr_q + 1'b1;
      else if (last_acc || st == IDLE) addr_q <= '0;

      if (go) begin
        mode_q <= bus.mode;
        acc_q  <= '0;
        all_q  <= '1;
        widx   <= '0;
        sv_q   <= 1'b0;
      end else if (acc_en) begin
        acc_q <= acc_d;
        all_q <= all_d;
        if (last_acc) begin
          scores_q <= acc_d;
          sunk_q   <= all_d;
          sv_q     <= 1'b1;
        end else begin
          widx <= widx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy = (st == SCAN) || (st == DRAIN);
    bus.done = (st == DONE);
  end

  assign bus.addr         = addr_q;
  assign bus.scores       = scores_q;
  assign bus.all_sunk     = sunk_q;
  assign bus.scores_valid = sv_q;

endmodule

// File: tb/tb_pontuacao_scan.sv
// tb_pontuacao_scan: three scanner variants (default, 4-bit score,
// 3-cycle memory) driven in lock-step against a fleet-level score model.
module tb_pontuacao_scan;

  localparam int N = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;

  always #5 clk = ~clk;

  pontuacao_scan_if #(.SCORE_W(6)) b0 ();
  pontuacao_scan_if #(.SCORE_W(4)) b1 ();
  pontuacao_scan_if #(.SCORE_W(6)) b2 ();

  pontuacao_scan #(.SCORE_W(6), .READ_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  pontuacao_scan #(.SCORE_W(4), .READ_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  pontuacao_scan #(.SCORE_W(6), .READ_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  logic [63:0]  fleet [2][N];
  logic [127:0] m0, m1, r1, r2, m2;

  function automatic logic [127:0] word(input logic [4:0] a);
    int i;
    i = (a < 5'(N)) ? int'(a) : 0;
    return {fleet[1][i], fleet[0][i]};
  endfunction

  always @(posedge clk) begin
    m0 <= word(b0.addr);
    m1 <= word(b1.addr);
    r1 <= word(b2.addr);
    r2 <= r1;
    m2 <= r2;
  end

  assign b0.start = start;
  assign b1.start = start;
  assign b2.start = start;
  assign b0.mode = mode;
  assign b1.mode = mode;
  assign b2.mode = mode;
  assign b0.memoria = m0;
  assign b1.memoria = m1;
  assign b2.memoria = m2;

  int total = 0;
  int bad = 0;
  int lat[3] = '{1, 1, 3};
  int sw[3] = '{6, 4, 6};
  int wt[N] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5};

  bit         dn[3], bz[3], sv[3];
  logic [4:0] ad[3];
  logic [7:0] s0[3], s1[3];
  logic [1:0] as[3];
  logic [7:0] e0[3], e1[3];
  logic [1:0] ea[3];
  bit         ev[3];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    dn[0] = b0.done; bz[0] = b0.busy; sv[0] = b0.scores_valid;
    dn[1] = b1.done; bz[1] = b1.busy; sv[1] = b1.scores_valid;
    dn[2] = b2.done; bz[2] = b2.busy; sv[2] = b2.scores_valid;
    ad[0] = b0.addr; ad[1] = b1.addr; ad[2] = b2.addr;
    s0[0] = {2'b0, b0.scores[5:0]}; s1[0] = {2'b0, b0.scores[11:6]};
    s0[1] = {4'b0, b1.scores[3:0]}; s1[1] = {4'b0, b1.scores[7:4]};
    s0[2] = {2'b0, b2.scores[5:0]}; s1[2] = {2'b0, b2.scores[11:6]};
    as[0] = b0.all_sunk; as[1] = b1.all_sunk; as[2] = b2.all_sunk;
  endtask

  task automatic chk_zero(input string tag);
    sample();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(ad[i]), 0);
      chk($sformatf("%s.busy%0d", tag, i), 32'(bz[i]), 0);
      chk($sformatf("%s.done%0d", tag, i), 32'(dn[i]), 0);
      chk($sformatf("%s.sv%0d", tag, i), 32'(sv[i]), 0);
      chk($sformatf("%s.sc%0d", tag, i), {16'b0, s1[i], s0[i]}, 0);
      chk($sformatf("%s.as%0d", tag, i), 32'(as[i]), 0);
      e0[i] = 0; e1[i] = 0; ea[i] = 0; ev[i] = 0;
    end
  endtask

  function automatic void model(input int swid, input bit m,
                                output logic [7:0] r0,
                                output logic [7:0] r1o,
                                output logic [1:0] ra);
    int tot[2];
    for (int p = 0; p < 2; p++) begin
      bit all = 1'b1;
      logic [63:0] w;
      tot[p] = 0;
      for (int a = 0; a < N; a++) begin
        bit sk;
        w = fleet[p][a];
        sk = (w[42:3] == 40'd0);
        all &= sk;
        if (m) tot[p] += sk ? 0 : 1;
        else if (sk) tot[p] += wt[a];
      end
      if (tot[p] > (1 << swid) - 1) tot[p] = (1 << swid) - 1;
      ra[p] = all;
    end
    r0 = 8'(tot[0]);
    r1o = 8'(tot[1]);
  endfunction

  task automatic set_fleet(input int p, input logic [N-1:0] sunk);
    logic [63:0] w;
    for (int a = 0; a < N; a++) begin
      w = {$urandom, $urandom};
      if (sunk[a]) w[42:3] = '0;
      else w[3 + int'($urandom_range(39, 0))] = 1'b1;
      fleet[p][a] = w;
    end
  endtask

  task automatic run_scan(input bit m, input int restart_k,
                          input int reset_k);
    logic [7:0] n0[3], n1[3];
    logic [1:0] na[3];
    for (int i = 0; i < 3; i++) model(sw[i], m, n0[i], n1[i], na[i]);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (reset_k > 0 && k == reset_k) begin
        chk_zero($sformatf("rst_mid_k%0d", k));
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          sample();
          for (int i = 0; i < 3; i++)
            chk($sformatf("nodone%0d_j%0d", i, j), 32'(dn[i]), 0);
        end
        return;
      end
      sample();
      for (int i = 0; i < 3; i++) begin
        int fin;
        bit nw;
        fin = N + lat[i];
        nw = (k >= fin);
        chk($sformatf("done%0d_k%0d", i, k), 32'(dn[i]), 32'(k == fin));
        chk($sformatf("busy%0d_k%0d", i, k), 32'(bz[i]), 32'(k < fin));
        chk($sformatf("sv%0d_k%0d", i, k), 32'(sv[i]), 32'(nw));
        chk($sformatf("p0_%0d_k%0d", i, k), 32'(s0[i]),
            32'(nw ? n0[i] : e0[i]));
        chk($sformatf("p1_%0d_k%0d", i, k), 32'(s1[i]),
            32'(nw ? n1[i] : e1[i]));
        chk($sformatf("as%0d_k%0d", i, k), 32'(as[i]),
            32'(nw ? na[i] : ea[i]));
        if (k < fin)
          chk($sformatf("addr%0d_k%0d", i, k), 32'(ad[i]),
              (k <= N - 1) ? k : N - 1);
        else if (k > fin)
          chk($sformatf("addr%0d_k%0d", i, k), 32'(ad[i]), 0);
      end
      if (k == restart_k - 1) start = 1'b1;
      if (k == restart_k) start = 1'b0;
      if (reset_k > 0 && k == reset_k - 1) rst_n = 1'b0;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e0[i] = n0[i]; e1[i] = n1[i]; ea[i] = na[i]; ev[i] = 1'b1;
    end
  endtask

  initial begin
    set_fleet(0, '0);
    set_fleet(1, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero("reset");

    set_fleet(0, 11'b10000100001);
    set_fleet(1, 11'b00000000000);
    run_scan(1'b0, 0, 0);

    set_fleet(0, '1);
    set_fleet(1, '1);
    run_scan(1'b0, 0, 0);

    set_fleet(0, 11'b00001111111);
    set_fleet(1, 11'b11111110111);
    run_scan(1'b1, 0, 0);

    set_fleet(0, 11'(($urandom)));
    set_fleet(1, 11'(($urandom)));
    run_scan(1'b0, 4, 0);

    set_fleet(0, 11'(($urandom)));
    set_fleet(1, 11'(($urandom)));
    run_scan(1'b1, 13, 0);

    set_fleet(0, '1);
    set_fleet(1, 11'b10000100001);
    run_scan(1'b0, 0, 6);

    set_fleet(0, 11'b10000100001);
    set_fleet(1, '1);
    run_scan(1'b0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] k0, k1;
      k0 = 11'($urandom);
      k1 = 11'($urandom);
      if (r % 5 == 0) k0 = '1;
      if (r % 7 == 1) k1 = '1;
      set_fleet(0, k0);
      set_fleet(1, k1);
      run_scan(1'($urandom), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pontuacao_scan.md
Name: pontuacao_scan

Overview:
- Parametrised successor to the two-player ship-scoring block.
- Scans every ship entry in N_PLAYERS fleet memories through one shared read address, using a start/done handshake.
- Accumulates a weighted score per player and flags fleets that are fully destroyed.
- Sits between the game controller (which drives start and consumes scores and all_sunk) and the per-player fleet memories.

Parameters:
N_PLAYERS, 2, number of players/fleet memories scanned in parallel
NUM_SHIPS, 11, ship entries per fleet; addresses 0..NUM_SHIPS-1
ADDR_W, 5, width of addr; must satisfy 2^ADDR_W >= NUM_SHIPS
DATA_W, 64, width of one fleet memory word
ALIVE_MSB, 42, top bit of the ship's alive-cell field
ALIVE_LSB, 3, bottom bit of the alive-cell field
READ_LAT, 1, memory read latency in cycles (0..3)
SCORE_W, 6, width of each player's score
WEIGHTS, 44'h54332211111, packed 4-bit weight per entry; entry i = WEIGHTS[4i+3:4i]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a scan; sampled only in IDLE
mode  in  1  0 = weighted sunk score, 1 = count of ships still afloat; sampled with start
memoria  in  N_PLAYERS*DATA_W  fleet words; player p occupies [p*DATA_W +: DATA_W]
addr  out  ADDR_W  shared read address to all fleet memories
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when scores/all_sunk are updated
scores_valid  out  1  high after first done; cleared by start or reset
scores  out  N_PLAYERS*SCORE_W  player p score at [p*SCORE_W +: SCORE_W]
all_sunk  out  N_PLAYERS  bit p = every ship of player p sunk

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE; all outputs 0.
  - Internal accumulators and the mode latch are cleared.
  - Reset mid-scan abandons the scan with no done pulse.
- A ship is sunk when memoria[p*DATA_W+ALIVE_MSB : p*DATA_W+ALIVE_LSB] is all zero.
- FSM states:
  - IDLE: addr=0, busy=0. On start=1:
    - latch mode, clear accumulators, clear scores_valid, set busy=1 → SCAN.
  - SCAN: addr increments by 1 each edge. At addr=NUM_SHIPS-1, hold addr → DRAIN.
  - DRAIN: waits until the last entry is accumulated, then → DONE.
  - DONE: one cycle with done=1, busy=0, scores_valid=1; addr returns to 0 → IDLE.
- Timing:
  - Define edge E0 as the edge that accepts start; addr=a is driven after edge Ea.
  - Data for address a is accumulated at edge E(a+1+READ_LAT).
  - The final accumulation and the update of the scores/all_sunk registers occur at edge E(NUM_SHIPS+READ_LAT).
  - done is high in the cycle after that edge. Defaults: done is high after E12.
  - An accepted start always produces exactly one done after NUM_SHIPS+READ_LAT+1 edges; back-to-back scans are possible the cycle after done.
- Accumulation per player, at each accumulation edge:
  - mode 0: add WEIGHTS entry a if ship a is sunk, else add 0.
  - mode 1: add 1 if ship a is afloat.
  - all_sunk accumulator is the AND over all entries of sunk(a).
- Arithmetic: unsigned adds at SCORE_W+1 bits, saturating at 2^SCORE_W-1; never wraps.
- Output stability:
  - scores and all_sunk hold their previous values for the whole scan and change only at the done-producing edge.
  - Between scans they hold indefinitely.
- Control rules:
  - start while busy is ignored (no restart, no queuing).
  - start sampled in the DONE cycle is ignored.
  - mode and memoria changes outside accumulation edges have no effect.
- Address bounds: addr never exceeds NUM_SHIPS-1, including when NUM_SHIPS=2^ADDR_W.
- Players are independent: one player's data never affects another's outputs.

Test Plan:
- Reset, then idle 5 cycles → addr=0, busy=0, done=0, scores=0, all_sunk=0, scores_valid=0.
- Defaults, mode 0, P1 entries 0,5,10 sunk and rest alive, P2 all alive; pulse start → addr 0..10 on consecutive cycles; done on the cycle after edge E12; scores P1=1+2+5=8, P2=0; all_sunk=2'b00.
- Mode 0, both fleets fully sunk → P1=24, P2=24, all_sunk=2'b11. Then SCORE_W=4, same stimulus → both saturate at 15.
- Mode 1, P1 ships 7..10 afloat, P2 ship 3 afloat → P1=4, P2=1; all_sunk=2'b00.
- start re-pulsed at E4 mid-scan → ignored, single done at the normal time. rst_n=0 at E6 of a new scan → no done, all outputs 0, next start scans normally.
- READ_LAT=3 with a memory model of latency 3 and the P1 pattern above → done after E14, P1=8; scores unchanged from prior values until that edge.
